spi_adc_slave_emu: RTL and testbench

Parametrised, system-clocked emulation of an SPI ADC slave of the AD7264 type, for bench and board bring-up of the SPI master. It oversamples the SPI pins on `clk`, deserialises a command word, holds MISO in high-Z for a programmable gap, then serialises one result word per channel on parallel MISO lines. It generalises the fixed 16/2/14, two-channel slave to arbitrary field widths and channel counts, and adds load buffering and frame-error detection.

---
 rtl/spi_adc_slave_emu_pkg.sv | 25 ++
 rtl/spi_adc_slave_emu_pin_sync.sv | 51 +++++
 rtl/spi_adc_slave_emu.sv | 179 +++++++++++++++++
 tb/tb_spi_adc_slave_emu.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_adc_slave_emu_pkg.sv
// Shared state type, default field widths and a constant-width helper for the SPI ADC slave emulator.
// Pure declarations: no logic, no latency, no flow control.
package spi_emu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECEIVE,
    TRISTATE,
    TRANSMIT,
    HOLD
  } spi_emu_state_t;

  localparam int DEF_NUM_CH   = 2;
  localparam int DEF_RX_BITS  = 16;
  localparam int DEF_TRI_BITS = 2;
  localparam int DEF_TX_BITS  = 14;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/spi_adc_slave_emu_pin_sync.sv
// Two-flop synchroniser plus registered edge detector for one asynchronous SPI pin.
// Level valid 2 clk after the pin, edge pulses 3 clk after; no backpressure.
module spi_pin_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic       rise_q, rise_d, fall_q, fall_d;
  logic [2:0] fill_q, fill_d;

  // Edges are suppressed until the history holds real pin samples, so a pin
  // that differs from RST_VAL at reset release does not look like an edge.
  always_comb begin
    s1_d   = pin;
    s2_d   = s1_q;
    s3_d   = s2_q;
    fill_d = {fill_q[1:0], 1'b1};
    rise_d = fill_q[2] & s2_q & ~s3_q;
    fall_d = fill_q[2] & ~s2_q & s3_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      s3_q   <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      fill_q <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      fill_q <= fill_d;
    end
  end

  assign level = s2_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_adc_slave_emu.sv
// clk-oversampled SPI ADC slave: receive command, tri-state gap, per-channel result words.
// miso/miso_oe change 4 clk after the causing pin edge; no backpressure (loads buffer one word).
module spi_adc_slave_emu
  import spi_emu_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int RX_BITS   = DEF_RX_BITS,
  parameter int TRI_BITS  = DEF_TRI_BITS,
  parameter int TX_BITS   = DEF_TX_BITS,
  parameter int FRAME_LEN = RX_BITS + TRI_BITS + TX_BITS + 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              sclk,
  input  logic                              ss_n,
  input  logic                              mosi,
  output logic [NUM_CH-1:0]                 miso,
  output logic [NUM_CH-1:0]                 miso_oe,
  input  logic [NUM_CH-1:0]                 load,
  input  logic [NUM_CH*TX_BITS-1:0]         load_data,
  output logic [RX_BITS-1:0]                rx_data,
  output logic                              rx_valid,
  output logic                              frame_error,
  output logic [clog2(FRAME_LEN+1)-1:0]     bit_count,
  output logic                              busy
);

  localparam int CNT_W = clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_RX  = CNT_W'(RX_BITS);
  localparam logic [CNT_W-1:0] CNT_TX0 = CNT_W'(RX_BITS + TRI_BITS);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(RX_BITS + TRI_BITS + TX_BITS);

  logic sclk_lvl, sclk_rise, fe;
  logic ss_lvl, ss_assert, ss_deassert;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_pin_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .pin(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(fe)
  );
  spi_pin_sync #(.RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .pin(ss_n), .level(ss_lvl), .rise(ss_deassert), .fall(ss_assert)
  );
  spi_pin_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .pin(mosi), .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_sync = &{1'b0, sclk_lvl, sclk_rise, ss_lvl, mosi_rise, mosi_fall};

  spi_emu_state_t       state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [RX_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic [RX_BITS-1:0]   rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_error_q, frame_error_d;
  logic                 oe_q, oe_d;
  logic                 tx_load, tx_shift_en;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_error_d = 1'b0;
    oe_d          = oe_q;
    tx_load       = 1'b0;
    tx_shift_en   = 1'b0;
    cnt_inc       = cnt_q + CNT_W'(1);

    if (ss_deassert) begin
      // HOLD is the only state where the master has clocked a complete frame.
      state_d       = IDLE;
      cnt_d         = '0;
      oe_d          = 1'b0;
      frame_error_d = (state_q == RECEIVE) || (state_q == TRISTATE) || (state_q == TRANSMIT);
    end else begin
      case (state_q)
        IDLE: begin
          oe_d  = 1'b0;
          cnt_d = '0;
          if (ss_assert) begin
            tx_load    = 1'b1;
            rx_shift_d = '0;
            state_d    = RECEIVE;
          end
        end
        RECEIVE: begin
          if (fe) begin
            cnt_d      = cnt_inc;
            rx_shift_d = {rx_shift_q[RX_BITS-2:0], mosi_s};
            if (cnt_inc == CNT_RX) begin
              rx_data_d  = rx_shift_d;
              rx_valid_d = 1'b1;
              state_d    = TRISTATE;
            end
          end
        end
        TRISTATE: begin
          if (fe) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_TX0) begin
              oe_d    = 1'b1;
              state_d = TRANSMIT;
            end
          end
        end
        TRANSMIT: begin
          // The LSB is already on the line when the last count is reached, so no shift then.
          if (fe) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_END) state_d = HOLD;
            else                    tx_shift_en = 1'b1;
          end
        end
        HOLD: begin
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      oe_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
      oe_q          <= oe_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [TX_BITS-1:0] pending_q, pending_d;
    logic [TX_BITS-1:0] tx_shift_q, tx_shift_d;

    // A load in the same cycle as the SS assert wins: the fresh word is copied.
    always_comb begin
      pending_d  = load[g] ? load_data[g*TX_BITS +: TX_BITS] : pending_q;
      tx_shift_d = tx_shift_q;
      if (tx_load)          tx_shift_d = pending_d;
      else if (tx_shift_en) tx_shift_d = {tx_shift_q[TX_BITS-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        pending_q  <= '0;
        tx_shift_q <= '0;
      end else begin
        pending_q  <= pending_d;
        tx_shift_q <= tx_shift_d;
      end
    end

    assign miso[g] = tx_shift_q[TX_BITS-1];
  end

  assign miso_oe     = {NUM_CH{oe_q}};
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_error = frame_error_q;
  assign bit_count   = cnt_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_spi_adc_slave_emu.sv
// Bench for spi_adc_slave_emu: default instance plus a 4-channel 8/3/12 instance on shared SPI pins.
// Drives an SPI master model (SCLK idles low, master samples MISO on the rising edge).
module tb_spi_adc_slave_emu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, sclk, ss_n, mosi;

  logic [1:0]  miso_a, oe_a, load_a;
  logic [27:0] load_data_a;
  logic [15:0] rx_data_a;
  logic        rxv_a, ferr_a, busy_a;
  logic [5:0]  bc_a;

  logic [3:0]  miso_b, oe_b, load_b;
  logic [47:0] load_data_b;
  logic [7:0]  rx_data_b;
  logic        rxv_b, ferr_b, busy_b;
  logic [4:0]  bc_b;

  spi_adc_slave_emu u_dut_a (
    .clk(clk), .reset(reset), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso_a), .miso_oe(oe_a), .load(load_a), .load_data(load_data_a),
    .rx_data(rx_data_a), .rx_valid(rxv_a), .frame_error(ferr_a),
    .bit_count(bc_a), .busy(busy_a)
  );

  spi_adc_slave_emu #(.NUM_CH(4), .RX_BITS(8), .TRI_BITS(3), .TX_BITS(12)) u_dut_b (
    .clk(clk), .reset(reset), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso_b), .miso_oe(oe_b), .load(load_b), .load_data(load_data_b),
    .rx_data(rx_data_b), .rx_valid(rxv_b), .frame_error(ferr_b),
    .bit_count(bc_b), .busy(busy_b)
  );

  int total = 0;
  int bad = 0;
  int rxv_cnt = 0;
  int ferr_cnt = 0;

  logic [15:0] rx_q[$];
  logic [27:0] word_q[$];
  logic [13:0] pend_a[2];
  logic [11:0] pend_b[4];
  logic [13:0] got_a[2];
  logic [11:0] got_b[4];

  typedef struct {
    logic [15:0] cmd;
    logic [13:0] w0;
    logic [13:0] w1;
    int          nper;
    int          exp_rxv;
    int          exp_ferr;
    logic [15:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sclk_period(input logic mo);
    sclk = 1'b1;
    mosi = mo;
    wait_clk(8);
    sclk = 1'b0;
    wait_clk(8);
  endtask

  task automatic load_a_words(input logic [13:0] w0, input logic [13:0] w1);
    load_data_a = {w1, w0};
    load_a = 2'b11;
    wait_clk(1);
    load_a = 2'b00;
    pend_a[0] = w0;
    pend_a[1] = w1;
  endtask

  task automatic load_b_default();
    for (int c = 0; c < 4; c++) begin
      load_data_b[c*12 +: 12] = 12'h100 + 12'(c);
      pend_b[c] = 12'h100 + 12'(c);
    end
    load_b = 4'hf;
    wait_clk(1);
    load_b = 4'h0;
  endtask

  // One SS-framed transfer of nper SCLK periods; optional ch0 load during period ld_per.
  task automatic run_frame(input logic [15:0] cmd, input int nper, input int ld_per,
                           input logic [13:0] ld_val);
    logic [11:0] pb[4];
    logic [3:0]  lsb_b;
    int          exp_bc_a;
    int          exp_bc_b;
    pb = pend_b;
    lsb_b = {pend_b[3][0], pend_b[2][0], pend_b[1][0], pend_b[0][0]};
    if (nper >= 16) rx_q.push_back(cmd);
    if (nper >= 32) word_q.push_back({pend_a[1], pend_a[0]});
    ss_n = 1'b0;
    wait_clk(8);
    for (int k = 1; k <= nper; k++) begin
      if (k >= 19 && k <= 32) for (int c = 0; c < 2; c++) got_a[c][32-k] = miso_a[c];
      if (k >= 12 && k <= 23) for (int c = 0; c < 4; c++) got_b[c][23-k] = miso_b[c];
      if (k == 17 || k == 18) chk("oe_a_tristate", oe_a, 2'b00);
      if (k == 19) chk("oe_a_transmit", oe_a, 2'b11);
      if (k >= 24 && k <= 27) begin
        chk("miso_b_hold_lsb", miso_b, lsb_b);
        chk("oe_b_hold", oe_b, 4'hf);
      end
      if (k == ld_per) begin
        load_data_a[13:0] = ld_val;
        load_a = 2'b01;
        wait_clk(1);
        load_a = 2'b00;
        pend_a[0] = ld_val;
      end
      sclk_period((k <= 16) ? cmd[16-k] : 1'b0);
    end
    wait_clk(4);
    exp_bc_a = (nper < 32) ? nper : 32;
    exp_bc_b = (nper < 23) ? nper : 23;
    chk("bit_count_a", bc_a, exp_bc_a);
    chk("bit_count_b", bc_b, exp_bc_b);
    chk("busy_a_in_frame", busy_a, 1);
    if (nper >= 32) chk("words_a", {got_a[1], got_a[0]}, word_q.pop_front());
    if (nper >= 23) for (int c = 0; c < 4; c++) chk("word_b", got_b[c], pb[c]);
    ss_n = 1'b1;
    wait_clk(8);
    chk("busy_a_after", busy_a, 0);
    chk("bit_count_a_after", bc_a, 0);
    chk("oe_a_after", oe_a, 2'b00);
  endtask

  always @(negedge clk) begin
    if (rxv_a === 1'b1) begin
      rxv_cnt++;
      if (rx_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_unexpected: got 0x%0h expected no rx_valid", rx_data_a);
      end else begin
        chk("rx_data", rx_data_a, rx_q.pop_front());
      end
    end
    if (ferr_a === 1'b1) ferr_cnt++;
  end

  initial begin
    int rv0;
    int fe0;
    logic [15:0] rcmd;

    vecs[0] = '{16'hA55A, 14'h1234, 14'h2ABC, 33, 1, 0, 16'hA55A};
    vecs[1] = '{16'h1111, 14'h1234, 14'h2ABC, 10, 0, 1, 16'hA55A};
    vecs[2] = '{16'h0F0F, 14'h3FFF, 14'h0001, 33, 1, 0, 16'h0F0F};
    vecs[3] = '{16'hFFFF, 14'h0000, 14'h3FFF, 33, 1, 0, 16'hFFFF};
    vecs[4] = '{16'h00C3, 14'h2AAA, 14'h1555, 33, 1, 0, 16'h00C3};

    reset = 1'b1;
    sclk = 1'b0;
    ss_n = 1'b1;
    mosi = 1'b0;
    load_a = '0;
    load_b = '0;
    load_data_a = '0;
    load_data_b = '0;
    pend_a = '{default: '0};
    pend_b = '{default: '0};
    wait_clk(4);
    chk("rst_miso_a", miso_a, 2'b00);
    chk("rst_oe_a", oe_a, 2'b00);
    chk("rst_rx_data_a", rx_data_a, 16'h0);
    chk("rst_rx_valid_a", rxv_a, 1'b0);
    chk("rst_frame_error_a", ferr_a, 1'b0);
    chk("rst_bit_count_a", bc_a, 0);
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_busy_b", busy_b, 1'b0);
    reset = 1'b0;
    wait_clk(6);
    chk("idle_after_reset", busy_a, 1'b0);
    load_b_default();

    for (int i = 0; i < 5; i++) begin
      load_a_words(vecs[i].w0, vecs[i].w1);
      rv0 = rxv_cnt;
      fe0 = ferr_cnt;
      run_frame(vecs[i].cmd, vecs[i].nper, 0, 14'h0);
      chk("rx_valid_count", rxv_cnt - rv0, vecs[i].exp_rxv);
      chk("frame_error_count", ferr_cnt - fe0, vecs[i].exp_ferr);
      chk("rx_data_after_frame", rx_data_a, vecs[i].exp_rx);
    end

    // Load during TRANSMIT only affects the next frame.
    load_a_words(14'h1234, 14'h0000);
    run_frame(16'h5A5A, 33, 25, 14'h3FFF);
    run_frame(16'h0001, 33, 0, 14'h0);

    // 27 periods: instance B holds its LSBs for the extra periods; A is cut short.
    rv0 = rxv_cnt;
    fe0 = ferr_cnt;
    run_frame(16'h3C00, 27, 0, 14'h0);
    chk("rx_data_b", rx_data_b, 8'h3C);
    chk("short_rx_valid_a", rxv_cnt - rv0, 1);
    chk("short_frame_error_a", ferr_cnt - fe0, 1);

    // Reset in the 25th SCLK period, with ss_n held low afterwards.
    load_a_words(14'h1555, 14'h2AAA);
    rcmd = 16'hC33C;
    rx_q.push_back(rcmd);
    fe0 = ferr_cnt;
    ss_n = 1'b0;
    wait_clk(8);
    for (int k = 1; k <= 24; k++) sclk_period((k <= 16) ? rcmd[16-k] : 1'b0);
    sclk = 1'b1;
    mosi = 1'b0;
    wait_clk(4);
    reset = 1'b1;
    wait_clk(1);
    chk("midrst_miso_a", miso_a, 2'b00);
    chk("midrst_oe_a", oe_a, 2'b00);
    chk("midrst_rx_data_a", rx_data_a, 16'h0);
    chk("midrst_rx_valid_a", rxv_a, 1'b0);
    chk("midrst_frame_error_a", ferr_a, 1'b0);
    chk("midrst_bit_count_a", bc_a, 0);
    chk("midrst_busy_a", busy_a, 1'b0);
    chk("midrst_miso_b", miso_b, 4'h0);
    chk("midrst_busy_b", busy_b, 1'b0);
    reset = 1'b0;
    pend_a = '{default: '0};
    pend_b = '{default: '0};
    wait_clk(3);
    sclk = 1'b0;
    wait_clk(8);
    repeat (3) sclk_period(1'b0);
    chk("ss_low_stays_idle", busy_a, 1'b0);
    chk("ss_low_bit_count", bc_a, 0);
    ss_n = 1'b1;
    wait_clk(8);
    chk("no_frame_error_on_reset", ferr_cnt - fe0, 0);
    run_frame(16'h8001, 33, 0, 14'h0);
    load_b_default();
    load_a_words(14'h0ABC, 14'h3001);
    run_frame(16'h7E81, 33, 0, 14'h0);

    wait_clk(4);
    chk("rx_queue_drained", rx_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
